// File: rtl/lsu_mem_responder.sv
// Data-side memory responder for the core's req/gnt/rvalid load/store port, with grant wait states and a fixed-latency response pipe.
// Optional pseudo-random grant stalls are enabled by defining LSU_MEM_RESPONDER_STALL_INJECT_EN.
module lsu_mem_responder #(
   parameter int    ADDR_WIDTH = 32,
   parameter int    DATA_WIDTH = 32,
   parameter int    MEM_WORDS  = 1024,
   parameter int    GNT_WAIT   = 0,
   parameter int    RSP_DELAY  = 1,
   parameter string INIT_FILE  = ""
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_i,
   input  logic [ADDR_WIDTH-1:0] addr_i,
   input  logic                  we_i,
   input  logic [3:0]            be_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   output logic                  gnt_o,
   output logic                  rvalid_o,
   output logic [DATA_WIDTH-1:0] rdata_o,
   output logic                  err_o
);

   localparam int                    IDX_W      = $clog2(MEM_WORDS);
   localparam logic [3:0]            WAIT_CNT   = 4'(GNT_WAIT);
   localparam logic [ADDR_WIDTH-1:0] WORD_LIMIT = ADDR_WIDTH'(MEM_WORDS);

   logic [DATA_WIDTH-1:0] mem_q [MEM_WORDS];

   logic [3:0]            wcnt_q;
   logic [3:0]            wcnt_d;
   logic                  stall_s;
   logic                  gnt_s;
   logic                  in_range_s;
   logic [IDX_W-1:0]      idx_s;
   logic [DATA_WIDTH-1:0] rd_word_s;
   logic [DATA_WIDTH-1:0] rsp_data_s;

   logic [RSP_DELAY-1:0]                 valid_q;
   logic [RSP_DELAY-1:0]                 err_q;
   logic [RSP_DELAY-1:0][DATA_WIDTH-1:0] data_q;

`ifdef LSU_MEM_RESPONDER_STALL_INJECT_EN
   logic [15:0] lfsr_q;

   // Fibonacci LFSR, taps 16/14/13/11, free-running every cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lfsr_q <= 16'hACE1;
      end else begin
         lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      end
   end

   assign stall_s = lfsr_q[0];
`else
   assign stall_s = 1'b0;
`endif

   assign idx_s      = addr_i[IDX_W+1:2];
   assign in_range_s = (addr_i >> 2) < WORD_LIMIT;
   assign rd_word_s  = mem_q[idx_s];
   assign gnt_s      = !rst && req_i && (wcnt_q == WAIT_CNT) && !stall_s;
   assign gnt_o      = gnt_s;
   assign rsp_data_s = (!we_i && in_range_s) ? rd_word_s : {DATA_WIDTH{1'b0}};

   // Wait counter: restarts on idle or grant, otherwise counts up and saturates.
   always_comb begin
      wcnt_d = wcnt_q;
      if (!req_i || gnt_s) begin
         wcnt_d = 4'd0;
`ifdef LSU_MEM_RESPONDER_STALL_INJECT_EN
      end else if (stall_s && (wcnt_q == WAIT_CNT)) begin
         wcnt_d = wcnt_q;
`endif
      end else if (wcnt_q != 4'd15) begin
         wcnt_d = wcnt_q + 4'd1;
      end else begin
         wcnt_d = wcnt_q;
      end
   end

   // Wait counter register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wcnt_q <= 4'd0;
      end else begin
         wcnt_q <= wcnt_d;
      end
   end

   // Byte-masked store at the edge closing the grant cycle; out-of-range stores are dropped.
   always_ff @(posedge clk) begin
      if (gnt_s && we_i && in_range_s) begin
         for (int k = 0; k < 4; k++) begin
            if (be_i[k]) begin
               mem_q[idx_s][8*k +: 8] <= wdata_i[8*k +: 8];
            end
         end
      end
   end

   // Response shift register; stage 0 captures the grant, the last stage drives the outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= '0;
         err_q   <= '0;
         data_q  <= '0;
      end else begin
         for (int k = RSP_DELAY - 1; k > 0; k--) begin
            valid_q[k] <= valid_q[k-1];
            err_q[k]   <= err_q[k-1];
            data_q[k]  <= data_q[k-1];
         end
         if (gnt_s) begin
            valid_q[0] <= 1'b1;
            err_q[0]   <= !in_range_s;
            data_q[0]  <= rsp_data_s;
         end else begin
            valid_q[0] <= 1'b0;
            err_q[0]   <= 1'b0;
            data_q[0]  <= {DATA_WIDTH{1'b0}};
         end
      end
   end

   assign rvalid_o = valid_q[RSP_DELAY-1];
   assign err_o    = err_q[RSP_DELAY-1];
   assign rdata_o  = data_q[RSP_DELAY-1];

endmodule

// File: tb/tb_lsu_mem_responder.sv
// Directed bench: four responder instances with different GNT_WAIT/RSP_DELAY, hand-computed expectations.
module tb_lsu_mem_responder;

   logic        clk;
   logic        rst;
   logic        req_s   [4];
   logic        we_s    [4];
   logic [31:0] addr_s  [4];
   logic [3:0]  be_s    [4];
   logic [31:0] wd_s    [4];
   logic        gnt_s   [4];
   logic        rv_s    [4];
   logic [31:0] rd_s    [4];
   logic        er_s    [4];

   int n_cmp;
   int n_err;

   lsu_mem_responder #(.GNT_WAIT(0), .RSP_DELAY(1)) u_d0 (
      .clk(clk), .rst(rst), .req_i(req_s[0]), .addr_i(addr_s[0]), .we_i(we_s[0]), .be_i(be_s[0]),
      .wdata_i(wd_s[0]), .gnt_o(gnt_s[0]), .rvalid_o(rv_s[0]), .rdata_o(rd_s[0]), .err_o(er_s[0]));

   lsu_mem_responder #(.GNT_WAIT(0), .RSP_DELAY(4)) u_d1 (
      .clk(clk), .rst(rst), .req_i(req_s[1]), .addr_i(addr_s[1]), .we_i(we_s[1]), .be_i(be_s[1]),
      .wdata_i(wd_s[1]), .gnt_o(gnt_s[1]), .rvalid_o(rv_s[1]), .rdata_o(rd_s[1]), .err_o(er_s[1]));

   lsu_mem_responder #(.GNT_WAIT(3), .RSP_DELAY(1)) u_d2 (
      .clk(clk), .rst(rst), .req_i(req_s[2]), .addr_i(addr_s[2]), .we_i(we_s[2]), .be_i(be_s[2]),
      .wdata_i(wd_s[2]), .gnt_o(gnt_s[2]), .rvalid_o(rv_s[2]), .rdata_o(rd_s[2]), .err_o(er_s[2]));

   lsu_mem_responder #(.GNT_WAIT(0), .RSP_DELAY(2)) u_d3 (
      .clk(clk), .rst(rst), .req_i(req_s[3]), .addr_i(addr_s[3]), .we_i(we_s[3]), .be_i(be_s[3]),
      .wdata_i(wd_s[3]), .gnt_o(gnt_s[3]), .rvalid_o(rv_s[3]), .rdata_o(rd_s[3]), .err_o(er_s[3]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic put(input int i, input logic r, input logic w, input logic [31:0] a,
                      input logic [3:0] b, input logic [31:0] d);
      req_s[i]  = r;
      we_s[i]   = w;
      addr_s[i] = a;
      be_s[i]   = b;
      wd_s[i]   = d;
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   task automatic wait_gnt(input int i, input logic w, input logic [31:0] a, input logic [3:0] b,
                           input logic [31:0] d, input int exp_wait, input string tag);
      int n;
      n = 0;
      put(i, 1'b1, w, a, b, d);
      mid();
      while (!gnt_s[i] && n < 20) begin
         nxt();
         mid();
         n++;
      end
      chk(tag, 32'(n), 32'(exp_wait));
      nxt();
      put(i, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
   endtask

   initial begin
      int rv_cnt;
      logic [31:0] exp_d;
      logic        exp_v;
      n_cmp = 0;
      n_err = 0;
      rst   = 1'b1;
      for (int i = 0; i < 4; i++) put(i, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
      nxt();
      nxt();

      // Reset state, grant forced low while reset is held
      put(0, 1'b1, 1'b0, 32'h0, 4'h0, 32'h0);
      mid();
      chk("rst_gnt", 32'(gnt_s[0]), 32'd0);
      chk("rst_rvalid", 32'(rv_s[0]), 32'd0);
      chk("rst_rdata", rd_s[0], 32'h0);
      chk("rst_err", 32'(er_s[0]), 32'd0);
      nxt();
      put(0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
      rst = 1'b0;
      nxt();
      mid();
      chk("idle_rvalid", 32'(rv_s[0]), 32'd0);
      nxt();

      // Zero-wait store then load of 0x40
      put(0, 1'b1, 1'b1, 32'h40, 4'hF, 32'hDEADBEEF);
      mid();
      chk("a_st_gnt", 32'(gnt_s[0]), 32'd1);
      nxt();
      put(0, 1'b1, 1'b0, 32'h40, 4'h0, 32'h0);
      mid();
      chk("a_ld_gnt", 32'(gnt_s[0]), 32'd1);
      chk("a_st_rvalid", 32'(rv_s[0]), 32'd1);
      chk("a_st_rdata", rd_s[0], 32'h0);
      chk("a_st_err", 32'(er_s[0]), 32'd0);
      nxt();
      put(0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
      mid();
      chk("a_ld_rvalid", 32'(rv_s[0]), 32'd1);
      chk("a_ld_rdata", rd_s[0], 32'hDEADBEEF);
      chk("a_ld_err", 32'(er_s[0]), 32'd0);
      nxt();
      mid();
      chk("a_rvalid_one_cycle", 32'(rv_s[0]), 32'd0);
      nxt();

      // Partial store over a full word
      put(0, 1'b1, 1'b1, 32'h44, 4'hF, 32'h11223344);
      nxt();
      put(0, 1'b1, 1'b1, 32'h44, 4'b0010, 32'h0000AA00);
      nxt();
      put(0, 1'b1, 1'b0, 32'h44, 4'h0, 32'h0);
      nxt();
      put(0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
      mid();
      chk("p_rvalid", 32'(rv_s[0]), 32'd1);
      chk("p_rdata", rd_s[0], 32'h1122AA44);
      nxt();

      // Out-of-range accesses at 0x1000 and the last in-range word 0xFFC
      put(0, 1'b1, 1'b1, 32'hFFC, 4'hF, 32'hCAFEF00D);
      nxt();
      put(0, 1'b1, 1'b1, 32'h0, 4'hF, 32'h12345678);
      nxt();
      put(0, 1'b1, 1'b1, 32'h1000, 4'hF, 32'hFFFFFFFF);
      mid();
      chk("e_st_gnt", 32'(gnt_s[0]), 32'd1);
      nxt();
      put(0, 1'b1, 1'b0, 32'h1000, 4'h0, 32'h0);
      mid();
      chk("e_st_rvalid", 32'(rv_s[0]), 32'd1);
      chk("e_st_err", 32'(er_s[0]), 32'd1);
      chk("e_st_rdata", rd_s[0], 32'h0);
      nxt();
      put(0, 1'b1, 1'b0, 32'h0, 4'h0, 32'h0);
      mid();
      chk("e_ld_err", 32'(er_s[0]), 32'd1);
      chk("e_ld_rdata", rd_s[0], 32'h0);
      nxt();
      put(0, 1'b1, 1'b0, 32'hFFC, 4'h0, 32'h0);
      mid();
      chk("e_word0_rdata", rd_s[0], 32'h12345678);
      chk("e_word0_err", 32'(er_s[0]), 32'd0);
      nxt();
      put(0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
      mid();
      chk("e_top_rdata", rd_s[0], 32'hCAFEF00D);
      chk("e_top_err", 32'(er_s[0]), 32'd0);
      nxt();

      // Pipelined responses, RSP_DELAY=4: four stores then four back-to-back loads
      for (int c = 0; c < 13; c++) begin
         if (c < 4) put(1, 1'b1, 1'b1, 32'(4 * (c + 1)), 4'hF, 32'(c + 1));
         else if (c < 8) put(1, 1'b1, 1'b0, 32'(4 * (c - 3)), 4'h0, 32'h0);
         else put(1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
         mid();
         if (c < 8) chk($sformatf("q_gnt_c%0d", c), 32'(gnt_s[1]), 32'd1);
         exp_v = (c >= 4 && c < 12);
         exp_d = (c >= 8 && c < 12) ? 32'(c - 7) : 32'h0;
         chk($sformatf("q_rvalid_c%0d", c), 32'(rv_s[1]), 32'(exp_v));
         if (exp_v) chk($sformatf("q_rdata_c%0d", c), rd_s[1], exp_d);
         nxt();
      end

      // GNT_WAIT=3: aborted request leaves no grant or response, then full wait again
      put(2, 1'b1, 1'b1, 32'h8, 4'hF, 32'h55AA55AA);
      mid();
      chk("w_abort_gnt0", 32'(gnt_s[2]), 32'd0);
      nxt();
      mid();
      chk("w_abort_gnt1", 32'(gnt_s[2]), 32'd0);
      nxt();
      put(2, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
      rv_cnt = 0;
      for (int c = 0; c < 4; c++) begin
         mid();
         if (rv_s[2]) rv_cnt++;
         nxt();
      end
      chk("w_abort_no_rsp", 32'(rv_cnt), 32'd0);
      wait_gnt(2, 1'b1, 32'h8, 4'hF, 32'h55AA55AA, 3, "w_st_wait");
      wait_gnt(2, 1'b0, 32'h8, 4'h0, 32'h0, 3, "w_ld_wait");
      mid();
      chk("w_ld_rvalid", 32'(rv_s[2]), 32'd1);
      chk("w_ld_rdata", rd_s[2], 32'h55AA55AA);
      nxt();
      mid();
      chk("w_ld_rvalid_drop", 32'(rv_s[2]), 32'd0);
      nxt();

      // Reset with two loads in flight, RSP_DELAY=2
      put(3, 1'b1, 1'b1, 32'h0, 4'hF, 32'hA5A5A5A5);
      nxt();
      put(3, 1'b1, 1'b0, 32'h0, 4'h0, 32'h0);
      nxt();
      nxt();
      rst = 1'b1;
      mid();
      chk("r_gnt", 32'(gnt_s[3]), 32'd0);
      chk("r_rvalid", 32'(rv_s[3]), 32'd0);
      chk("r_rdata", rd_s[3], 32'h0);
      chk("r_err", 32'(er_s[3]), 32'd0);
      nxt();
      rst = 1'b0;
      put(3, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
      rv_cnt = 0;
      for (int c = 0; c < 5; c++) begin
         mid();
         if (rv_s[3]) rv_cnt++;
         nxt();
      end
      chk("r_no_rsp_after", 32'(rv_cnt), 32'd0);
      put(3, 1'b1, 1'b0, 32'h0, 4'h0, 32'h0);
      mid();
      chk("r_ld_gnt", 32'(gnt_s[3]), 32'd1);
      nxt();
      put(3, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
      nxt();
      mid();
      chk("r_ld_rvalid", 32'(rv_s[3]), 32'd1);
      chk("r_ld_rdata", rd_s[3], 32'hA5A5A5A5);
      nxt();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
